// File: rtl/perf_cnt_pkg.sv
// Shared types and helpers for the performance-counter bank.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package perf_cnt_pkg;

    // Counter behaviour when an enabled increment hits the all-ones value.
    typedef enum logic {
        WRAP = 1'b0,
        SAT  = 1'b1
    } cnt_mode_e;

    // Read-index width: max(1, clog2(num_ch)), so a single channel still
    // gets a 1-bit index port.
    function automatic int idx_w(input int num_ch);
        return (num_ch <= 2) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/perf_cnt_if.sv
// Snapshot read bus between a requester and the counter bank.
// Latency: response one cycle after the request edge.
// Backpressure: none; a request is accepted every cycle, there is no ready.
// Signals: rd_req_in/rd_idx_in (requester -> bank),
//          rd_valid_out/rd_data_out (bank -> requester).
interface perf_cnt_if #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = 2
);
    logic                  rd_req_in;
    logic [IDX_W-1:0]      rd_idx_in;
    logic                  rd_valid_out;
    logic [DATA_WIDTH-1:0] rd_data_out;

    modport master (
        output rd_req_in,
        output rd_idx_in,
        input  rd_valid_out,
        input  rd_data_out
    );

    modport slave (
        input  rd_req_in,
        input  rd_idx_in,
        output rd_valid_out,
        output rd_data_out
    );
endinterface

// File: rtl/perf_cnt_ch.sv
// One counter channel: registered count with sticky overflow flag.
// Latency: count/flag update on the edge where en_i/clr_i are sampled.
// Backpressure: none; every enabled cycle counts.
// Ports: clk, rst_n (async active-low), en_i, clr_i -> cnt_o, ovf_o.
module perf_cnt_ch
    import perf_cnt_pkg::*;
#(
    parameter int        DATA_WIDTH = 32,
    parameter cnt_mode_e MODE       = WRAP
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_i,
    input  logic                  clr_i,
    output logic [DATA_WIDTH-1:0] cnt_o,
    output logic                  ovf_o
);

    logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  at_max;

    assign at_max = &cnt_q;

    // Clear wins over an increment, including one that would overflow,
    // so a clear always leaves the flag low.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (en_i) begin
            if (at_max) begin
                ovf_d = 1'b1;
                cnt_d = (MODE == SAT) ? cnt_q : '0;
            end else begin
                cnt_d = cnt_q + DATA_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/perf_cnt_bank.sv
// Bank of NUM_CH performance counters with a global snapshot and a read port.
// Latency: counts update on the sampling edge; snapshot reads return 1 cycle later.
// Backpressure: none; reads accepted every cycle, counters never stall.
// Ports: clk, rst_n, en_in/clr_in (per channel), snap_in, rd_if (slave read
//        bus), ovf_out (sticky flags), cnt_out (live counts, ch0 in LSBs).
module perf_cnt_bank
    import perf_cnt_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4,
    parameter int SATURATE   = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            en_in,
    input  logic [NUM_CH-1:0]            clr_in,
    input  logic                         snap_in,
    perf_cnt_if.slave                    rd_if,
    output logic [NUM_CH-1:0]            ovf_out,
    output logic [NUM_CH*DATA_WIDTH-1:0] cnt_out
);

    localparam int        IDX_W = idx_w(NUM_CH);
    localparam cnt_mode_e MODE  = (SATURATE != 0) ? SAT : WRAP;

    logic [DATA_WIDTH-1:0] ch_cnt [NUM_CH];
    logic [DATA_WIDTH-1:0] snap_q [NUM_CH];
    logic [DATA_WIDTH-1:0] rd_sel;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q,  rd_data_d;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        perf_cnt_ch #(
            .DATA_WIDTH (DATA_WIDTH),
            .MODE       (MODE)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .en_i  (en_in[g]),
            .clr_i (clr_in[g]),
            .cnt_o (ch_cnt[g]),
            .ovf_o (ovf_out[g])
        );
        assign cnt_out[g*DATA_WIDTH +: DATA_WIDTH] = ch_cnt[g];
    end

    // Snapshot takes the registered counts, i.e. the value before this
    // edge's increment or clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) snap_q[i] <= '0;
        end else if (snap_in) begin
            for (int i = 0; i < NUM_CH; i++) snap_q[i] <= ch_cnt[i];
        end
    end

    // Compare-based mux: an index past the last channel matches nothing and
    // returns zero rather than aliasing onto a real entry.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_if.rd_idx_in == IDX_W'(i)) rd_sel = snap_q[i];
        end
    end

    // Data is zeroed when no request so rd_data_out is 0 whenever not valid.
    always_comb begin
        rd_valid_d = rd_if.rd_req_in;
        rd_data_d  = rd_if.rd_req_in ? rd_sel : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_if.rd_valid_out = rd_valid_q;
    assign rd_if.rd_data_out  = rd_data_q;

endmodule

// File: tb/tb_perf_cnt_bank.sv
// Bench for perf_cnt_bank: two instances (4ch wrap, 3ch saturate, 4-bit counters).
// Latency: n/a.
// Backpressure: n/a.
module tb_perf_cnt_bank;
    import perf_cnt_pkg::*;

    localparam int MAXV = 15;

    logic clk;
    logic rst_n;

    // Instance A: 4 channels, wrapping.
    logic [3:0]  a_en, a_clr;
    logic        a_snap, a_req;
    logic [1:0]  a_idx;
    logic [3:0]  ovf_a;
    logic [15:0] cnt_a;
    // Instance B: 3 channels, saturating.
    logic [2:0]  b_en, b_clr;
    logic        b_snap, b_req;
    logic [1:0]  b_idx;
    logic [2:0]  ovf_b;
    logic [11:0] cnt_b;

    perf_cnt_if #(.DATA_WIDTH(4), .IDX_W(idx_w(4))) if_a ();
    perf_cnt_if #(.DATA_WIDTH(4), .IDX_W(idx_w(3))) if_b ();

    assign if_a.rd_req_in = a_req;
    assign if_a.rd_idx_in = a_idx;
    assign if_b.rd_req_in = b_req;
    assign if_b.rd_idx_in = b_idx;

    perf_cnt_bank #(.DATA_WIDTH(4), .NUM_CH(4), .SATURATE(0)) dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_in   (a_en),
        .clr_in  (a_clr),
        .snap_in (a_snap),
        .rd_if   (if_a),
        .ovf_out (ovf_a),
        .cnt_out (cnt_a)
    );

    perf_cnt_bank #(.DATA_WIDTH(4), .NUM_CH(3), .SATURATE(1)) dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_in   (b_en),
        .clr_in  (b_clr),
        .snap_in (b_snap),
        .rd_if   (if_b),
        .ovf_out (ovf_b),
        .cnt_out (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, index 0 = A, 1 = B.
    int m_cnt  [2][4];
    int m_ovf  [2][4];
    int m_snap [2][4];
    int m_rv   [2];
    int m_rd   [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_rv[d] = 0;
            m_rd[d] = 0;
            for (int i = 0; i < 4; i++) begin
                m_cnt[d][i] = 0; m_ovf[d][i] = 0; m_snap[d][i] = 0;
            end
        end
    endtask

    // One clock edge of the specified behaviour, in plain integer arithmetic.
    task automatic model_edge(input int d, input int n, input bit sat,
                              input logic [3:0] en, input logic [3:0] clr,
                              input bit snap, input bit req, input int idx);
        m_rv[d] = req ? 1 : 0;
        m_rd[d] = (req && idx < n) ? m_snap[d][idx] : 0;
        if (snap) for (int i = 0; i < n; i++) m_snap[d][i] = m_cnt[d][i];
        for (int i = 0; i < n; i++) begin
            if (clr[i]) begin
                m_cnt[d][i] = 0;
                m_ovf[d][i] = 0;
            end else if (en[i]) begin
                if (m_cnt[d][i] + 1 > MAXV) begin
                    m_ovf[d][i] = 1;
                    m_cnt[d][i] = sat ? MAXV : (m_cnt[d][i] + 1) % (MAXV + 1);
                end else begin
                    m_cnt[d][i] = m_cnt[d][i] + 1;
                end
            end
        end
    endtask

    task automatic check_model();
        logic [3:0] eo;
        eo = '0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("a_cnt%0d", i), 32'(cnt_a[i*4 +: 4]), m_cnt[0][i]);
            eo[i] = (m_ovf[0][i] != 0);
        end
        chk("a_ovf", 32'(ovf_a), 32'(eo));
        chk("a_rv", 32'(if_a.rd_valid_out), m_rv[0]);
        chk("a_rd", 32'(if_a.rd_data_out), m_rd[0]);
        eo = '0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("b_cnt%0d", i), 32'(cnt_b[i*4 +: 4]), m_cnt[1][i]);
            eo[i] = (m_ovf[1][i] != 0);
        end
        chk("b_ovf", 32'(ovf_b), 32'(eo));
        chk("b_rv", 32'(if_b.rd_valid_out), m_rv[1]);
        chk("b_rd", 32'(if_b.rd_data_out), m_rd[1]);
    endtask

    // Advance one edge, update the model with the inputs the DUT sampled,
    // then compare just after the edge.
    task automatic cycle();
        @(posedge clk);
        if (rst_n) begin
            model_edge(0, 4, 1'b0, a_en, a_clr, a_snap, a_req, int'(a_idx));
            model_edge(1, 3, 1'b1, {1'b0, b_en}, {1'b0, b_clr}, b_snap, b_req, int'(b_idx));
        end else begin
            model_reset();
        end
        #1;
        check_model();
    endtask

    task automatic idle_inputs();
        a_en = '0; a_clr = '0; a_snap = 1'b0; a_req = 1'b0; a_idx = '0;
        b_en = '0; b_clr = '0; b_snap = 1'b0; b_req = 1'b0; b_idx = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  en;
        logic [3:0]  clr;
        logic        snap;
        logic        req;
        logic [1:0]  idx;
        logic [15:0] cnt;
        logic [3:0]  ovf;
        logic        rv;
        logic [3:0]  rd;
    } vec_t;

    vec_t vecs [13];

    initial begin
        // Build up distinct counts, snapshot with a same-edge increment,
        // read back-to-back, then snapshot+clear+read on one edge.
        vecs[0]  = '{4'b0011, 4'b0000, 1'b0, 1'b0, 2'd0, 16'h0011, 4'b0000, 1'b0, 4'h0};
        vecs[1]  = '{4'b0011, 4'b0000, 1'b0, 1'b0, 2'd0, 16'h0022, 4'b0000, 1'b0, 4'h0};
        vecs[2]  = '{4'b0011, 4'b0000, 1'b0, 1'b0, 2'd0, 16'h0033, 4'b0000, 1'b0, 4'h0};
        vecs[3]  = '{4'b1110, 4'b0000, 1'b0, 1'b0, 2'd0, 16'h1143, 4'b0000, 1'b0, 4'h0};
        vecs[4]  = '{4'b0110, 4'b0000, 1'b0, 1'b0, 2'd0, 16'h1253, 4'b0000, 1'b0, 4'h0};
        vecs[5]  = '{4'b0010, 4'b0000, 1'b1, 1'b0, 2'd0, 16'h1263, 4'b0000, 1'b0, 4'h0};
        vecs[6]  = '{4'b0000, 4'b0000, 1'b0, 1'b1, 2'd1, 16'h1263, 4'b0000, 1'b1, 4'h5};
        vecs[7]  = '{4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0, 16'h1263, 4'b0000, 1'b1, 4'h3};
        vecs[8]  = '{4'b0000, 4'b0000, 1'b0, 1'b1, 2'd2, 16'h1263, 4'b0000, 1'b1, 4'h2};
        vecs[9]  = '{4'b0000, 4'b0000, 1'b0, 1'b1, 2'd3, 16'h1263, 4'b0000, 1'b1, 4'h1};
        vecs[10] = '{4'b0000, 4'b0010, 1'b1, 1'b1, 2'd1, 16'h1203, 4'b0000, 1'b1, 4'h5};
        vecs[11] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 2'd1, 16'h1203, 4'b0000, 1'b1, 4'h6};
        vecs[12] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 16'h1203, 4'b0000, 1'b0, 4'h0};

        idle_inputs();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_cnt_a", 32'(cnt_a), 0);
        chk("rst_cnt_b", 32'(cnt_b), 0);
        chk("rst_ovf_a", 32'(ovf_a), 0);
        chk("rst_rv_a", 32'(if_a.rd_valid_out), 0);
        chk("rst_rd_a", 32'(if_a.rd_data_out), 0);
        do_reset();

        // Table-driven directed vectors on instance A.
        for (int v = 0; v < 13; v++) begin
            a_en = vecs[v].en; a_clr = vecs[v].clr; a_snap = vecs[v].snap;
            a_req = vecs[v].req; a_idx = vecs[v].idx;
            cycle();
            chk($sformatf("tbl%0d_cnt", v), 32'(cnt_a), 32'(vecs[v].cnt));
            chk($sformatf("tbl%0d_ovf", v), 32'(ovf_a), 32'(vecs[v].ovf));
            chk($sformatf("tbl%0d_rv", v), 32'(if_a.rd_valid_out), 32'(vecs[v].rv));
            chk($sformatf("tbl%0d_rd", v), 32'(if_a.rd_data_out), 32'(vecs[v].rd));
        end

        // 17 increments: A wraps to 1, B saturates at 15; both flag overflow.
        idle_inputs();
        do_reset();
        a_en = 4'b0001; b_en = 3'b001;
        repeat (17) cycle();
        chk("wrap17_cnt", 32'(cnt_a), 32'h0001);
        chk("wrap17_ovf", 32'(ovf_a), 32'b0001);
        chk("sat17_cnt", 32'(cnt_b), 32'h00F);
        chk("sat17_ovf", 32'(ovf_b), 32'b001);

        // B: clear with snapshot on the same edge (snapshot keeps 15).
        a_en = 4'b0100; b_en = 3'b000; b_clr = 3'b001; b_snap = 1'b1;
        cycle();
        chk("sat_clr_cnt", 32'(cnt_b), 0);
        chk("sat_clr_ovf", 32'(ovf_b), 0);
        chk("ovf_sticky_a", 32'(ovf_a), 32'b0001);
        // B has 3 channels: idx 3 is out of range and must read as zero.
        b_clr = '0; b_snap = 1'b0; b_req = 1'b1; b_idx = 2'd3;
        cycle();
        chk("oor_rv", 32'(if_b.rd_valid_out), 1);
        chk("oor_rd", 32'(if_b.rd_data_out), 0);
        b_idx = 2'd0;
        cycle();
        chk("snap_after_clr_rd", 32'(if_b.rd_data_out), 15);
        b_req = 1'b0;
        repeat (12) cycle();
        chk("ch2_at_max", 32'(cnt_a), 32'h0F01);
        chk("ch2_no_ovf", 32'(ovf_a), 32'b0001);
        // Clear beats a simultaneous overflowing increment.
        a_clr = 4'b0100;
        cycle();
        chk("clr_vs_ovf_cnt", 32'(cnt_a), 32'h0001);
        chk("clr_vs_ovf_flag", 32'(ovf_a), 32'b0001);

        // Reset between request and response handling.
        idle_inputs();
        a_snap = 1'b1;
        cycle();
        a_snap = 1'b0; a_req = 1'b1; a_idx = 2'd0;
        cycle();
        chk("pre_rst_rv", 32'(if_a.rd_valid_out), 1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_rv", 32'(if_a.rd_valid_out), 0);
        chk("mid_rst_rd", 32'(if_a.rd_data_out), 0);
        chk("mid_rst_cnt", 32'(cnt_a), 0);
        chk("mid_rst_ovf", 32'(ovf_a), 0);
        a_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        a_en = 4'b0001;
        cycle();
        chk("post_rst_first_edge", 32'(cnt_a), 32'h0001);
        chk("post_rst_no_resp", 32'(if_a.rd_valid_out), 0);
        a_en = '0; a_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_idx = 2'(i);
            cycle();
            chk($sformatf("post_rst_snap%0d", i), 32'(if_a.rd_data_out), 0);
        end

        // Randomized traffic against the model; clears kept rare so counters
        // regularly reach wrap/saturation.
        for (int c = 0; c < 600; c++) begin
            a_en = 4'($urandom); b_en = 3'($urandom);
            for (int i = 0; i < 4; i++) a_clr[i] = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < 3; i++) b_clr[i] = ($urandom_range(0, 63) == 0);
            a_snap = ($urandom_range(0, 7) == 0);
            b_snap = ($urandom_range(0, 7) == 0);
            a_req = 1'($urandom); b_req = 1'($urandom);
            a_idx = 2'($urandom); b_idx = 2'($urandom);
            cycle();
        end

        idle_inputs();
        cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/perf_cnt_bank.md
PERF_CNT_BANK -- requirements
Module: perf_cnt_bank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of each counter.
REQ-002 SHALL have parameter NUM_CH, default 4: number of independent counter channels (1..64).
REQ-003 SHALL have parameter SATURATE, default 0: 0 = counters wrap at max, 1 = counters hold at max.
REQ-004 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port en_in  input  NUM_CH  per-channel increment enable.
REQ-007 SHALL have port clr_in  input  NUM_CH  per-channel synchronous clear of counter and overflow flag.
REQ-008 SHALL have port snap_in  input  1  global snapshot strobe; copies all live counts into the snapshot bank.
REQ-009 SHALL have port rd_req_in  input  1  read request for one snapshot entry.
REQ-010 SHALL have port rd_idx_in  input  IDX_W  channel index of the read; IDX_W = max(1, clog2(NUM_CH)).
REQ-011 SHALL have port rd_valid_out  output  1  read data valid, one-cycle pulse.
REQ-012 SHALL have port rd_data_out  output  DATA_WIDTH  snapshot value returned by the read.
REQ-013 SHALL have port ovf_out  output  NUM_CH  sticky per-channel overflow/saturation flag.
REQ-014 SHALL have port cnt_out  output  NUM_CH*DATA_WIDTH  live counts, channel 0 in the LSBs.

Function
REQ-015 Each clock, channel i SHALL: clr_in[i]=1 -> count 0, ovf 0; else en_in[i]=1 -> count+1 (per REQ-016/017); else hold.
REQ-016 With SATURATE=0 and count = 2^DATA_WIDTH-1 and enabled, count SHALL wrap to 0 and ovf_out[i] SHALL set.
REQ-017 With SATURATE=1 and count = 2^DATA_WIDTH-1 and enabled, count SHALL hold at max and ovf_out[i] SHALL set.
REQ-018 ovf_out[i] SHALL stay set until clr_in[i] or reset; clr_in has priority over a simultaneous overflow event.
REQ-019 snap_in=1 SHALL load every snapshot entry with the live count present before that edge's update (simultaneous increment not captured).
REQ-020 Snapshot bank SHALL be unaffected by clr_in and en_in; only snap_in and reset change it.
REQ-021 rd_req_in=1 at edge N SHALL produce rd_valid_out=1 for exactly the cycle after edge N, latency 1.
REQ-022 rd_data_out SHALL equal the snapshot entry rd_idx_in selected at edge N, as held before edge N (snap_in at edge N not visible).
REQ-023 rd_idx_in >= NUM_CH SHALL return rd_data_out = 0 with rd_valid_out still asserted.
REQ-024 Back-to-back reads SHALL be accepted every cycle with no stall; no ready signal exists.
REQ-025 rd_data_out SHALL be 0 whenever rd_valid_out=0.
REQ-026 cnt_out SHALL reflect registered counts (no combinational path from en_in/clr_in).

Reset
REQ-027 rst_n low SHALL asynchronously force all counts, snapshot entries, ovf_out, rd_valid_out and rd_data_out to 0.
REQ-028 Reset asserted mid-read SHALL drop rd_valid_out immediately; no read response after reset release.
REQ-029 First edge after rst_n rises SHALL operate normally (no dead cycle).

Structure
REQ-030 Package perf_cnt_pkg SHALL hold the counter mode enum (WRAP, SAT) and the IDX_W width helper function.
REQ-031 One channel (count, ovf, wrap/saturate logic) SHALL be a sub-module perf_cnt_ch, instantiated NUM_CH times by generate.
REQ-032 Snapshot bank and read mux SHALL live in the top level; total RTL 120-400 lines.

Verification (DATA_WIDTH=4, NUM_CH=4 unless stated)
REQ-033 en_in=4'b0001 for 17 cycles, SATURATE=0 -> ch0 count 1, ovf_out=4'b0001, other channels 0.
REQ-034 Same stimulus, SATURATE=1 -> ch0 count 15, ovf_out[0]=1; then clr_in[0] pulse -> count 0, ovf 0.
REQ-035 ch1 at 5, snap_in and en_in[1] same cycle, then rd_req_in idx=1 -> rd_valid_out one cycle later, rd_data_out=5, cnt ch1=6.
REQ-036 rd_req_in held 4 cycles with idx 0,1,2,3 -> four consecutive rd_valid_out cycles returning snapshots in order; idx=5 (NUM_CH=4, IDX_W=2 wraps, so use NUM_CH=3) -> data 0.
REQ-037 clr_in[2] and en_in[2] same cycle at count 15 -> count 0, ovf_out[2]=0.
REQ-038 rst_n low between rd_req_in and response -> rd_valid_out 0 immediately, all counts/snapshots/ovf 0 after release.
